gpr_wb_regfile: RTL and testbench

//  Integer register file (x0..x31) at the write-back end of the execute stage: takes the single committed

---
 rtl/gpr_pkg.sv | 12 +
 rtl/gpr_scoreboard.sv | 65 ++++++
 rtl/gpr_wb_regfile.sv | 69 ++++++
 tb/tb_gpr_wb_regfile.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and constants for the write-back GPR file and its pending-write scoreboard.
package gpr_pkg;

    localparam int REG_NUM = 32;
    localparam int XLEN    = 32;

    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard for long-latency producers: set/clear/flush priority, decode stall and idle.
// Optional macro GPR_WB_BYPASS_EN: stall ignores a pending bit whose clearing write is present this cycle.
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  logic      issue_i,
    input  reg_addr_t issue_rd_i,
    input  logic      flush_i,
    input  reg_addr_t dec_rs1_i,
    input  reg_addr_t dec_rs2_i,
    input  reg_addr_t dec_rd_i,
    output logic      stall_o,
    output logic      idle_o
);

    logic [REG_NUM-1:0] pending_q;
    logic [REG_NUM-1:0] pending_d;
    logic [REG_NUM-1:0] clr_mask;
    logic [REG_NUM-1:0] set_mask;
    logic [REG_NUM-1:0] visible;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (we_i && (waddr_i != ZERO_REG)) begin
            clr_mask[waddr_i] = 1'b1;
        end
        if (issue_i && (issue_rd_i != ZERO_REG)) begin
            set_mask[issue_rd_i] = 1'b1;
        end
    end

    // Set wins over a same-cycle clear; flush overrides both.
    always_comb begin
        if (flush_i) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~clr_mask) | set_mask;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
`ifdef GPR_WB_BYPASS_EN
        visible = pending_q & ~clr_mask;
`else
        visible = pending_q;
`endif
        stall_o = visible[dec_rs1_i] | visible[dec_rs2_i] | visible[dec_rd_i];
        idle_o  = ~|pending_q;
    end

endmodule

// File: rtl/gpr_wb_regfile.sv
// Write-back integer register file (x0 hardwired zero) with two combinational read ports.
// Optional macro GPR_WB_BYPASS_EN: same-cycle commit write forwarded to the read ports.
module gpr_wb_regfile
    import gpr_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we_i,
    input  reg_addr_t waddr_i,
    input  reg_data_t wdata_i,
    input  reg_addr_t raddr1_i,
    output reg_data_t rdata1_o,
    input  reg_addr_t raddr2_i,
    output reg_data_t rdata2_o,
    input  logic      issue_i,
    input  reg_addr_t issue_rd_i,
    input  reg_addr_t dec_rs1_i,
    input  reg_addr_t dec_rs2_i,
    input  reg_addr_t dec_rd_i,
    input  logic      flush_i,
    output logic      stall_o,
    output logic      idle_o
);

    reg_data_t gpr_q [REG_NUM];
    logic      wr_en;

    assign wr_en = we_i && (waddr_i != ZERO_REG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wr_en) begin
            gpr_q[waddr_i] <= wdata_i;
        end
    end

    // Forwarding is gated by rst so the read ports stay zero throughout reset.
    always_comb begin
        rdata1_o = (raddr1_i == ZERO_REG) ? '0 : gpr_q[raddr1_i];
        rdata2_o = (raddr2_i == ZERO_REG) ? '0 : gpr_q[raddr2_i];
`ifdef GPR_WB_BYPASS_EN
        if (!rst && wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
        if (!rst && wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
`endif
    end

    gpr_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .flush_i    (flush_i),
        .dec_rs1_i  (dec_rs1_i),
        .dec_rs2_i  (dec_rs2_i),
        .dec_rd_i   (dec_rd_i),
        .stall_o    (stall_o),
        .idle_o     (idle_o)
    );

endmodule

// File: tb/tb_gpr_wb_regfile.sv
// Scoreboard bench for gpr_wb_regfile: directed hazard scenarios plus random traffic against a reference model.
module tb_gpr_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic        issue_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic [4:0]  dec_rs1_i = '0;
    logic [4:0]  dec_rs2_i = '0;
    logic [4:0]  dec_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        issue;
        logic [4:0]  ird;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        flush;
    } stim_t;

    typedef struct {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic        stall;
        logic        idle;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural register values and the set of outstanding destinations.
    logic [31:0] gpr_m [32];
    logic        pend_m [32];

    gpr_wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .we_i       (we_i),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .issue_i    (issue_i),
        .issue_rd_i (issue_rd_i),
        .dec_rs1_i  (dec_rs1_i),
        .dec_rs2_i  (dec_rs2_i),
        .dec_rd_i   (dec_rd_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .idle_o     (idle_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t nop();
        stim_t s;
        s.we = 1'b0; s.waddr = '0; s.wdata = '0;
        s.r1 = '0; s.r2 = '0;
        s.issue = 1'b0; s.ird = '0;
        s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        s.flush = 1'b0;
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input stim_t s);
        if (a == 0) return 32'h0;
`ifdef GPR_WB_BYPASS_EN
        if (s.we && s.waddr == a) return s.wdata;
`endif
        return gpr_m[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a, input stim_t s);
        if (a == 0) return 1'b0;
`ifdef GPR_WB_BYPASS_EN
        if (s.we && s.waddr == a) return 1'b0;
`endif
        return pend_m[a];
    endfunction

    function automatic logic model_stall(input stim_t s);
        return model_busy(s.rs1, s) || model_busy(s.rs2, s) || model_busy(s.rd, s);
    endfunction

    function automatic logic model_idle();
        for (int i = 0; i < 32; i++) if (pend_m[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            gpr_m[i]  = 32'h0;
            pend_m[i] = 1'b0;
        end
    endtask

    // Called at posedge+1: drive, predict, advance one clock, update the model.
    task automatic apply(input stim_t s, input string tag);
        exp_t e;
        we_i = s.we; waddr_i = s.waddr; wdata_i = s.wdata;
        raddr1_i = s.r1; raddr2_i = s.r2;
        issue_i = s.issue; issue_rd_i = s.ird;
        dec_rs1_i = s.rs1; dec_rs2_i = s.rs2; dec_rd_i = s.rd;
        flush_i = s.flush;
        e.rdata1 = model_read(s.r1, s);
        e.rdata2 = model_read(s.r2, s);
        e.stall  = model_stall(s);
        e.idle   = model_idle();
        e.tag    = tag;
        exp_q.push_back(e);
        @(posedge clk);
        if (s.we && s.waddr != 0) begin
            gpr_m[s.waddr]  = s.wdata;
            pend_m[s.waddr] = 1'b0;
        end
        if (s.issue && s.ird != 0) pend_m[s.ird] = 1'b1;
        if (s.flush) for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
        #1;
    endtask

    // Reset held across one full cycle while random inputs are presented.
    task automatic do_reset(input string tag);
        exp_t e;
        stim_t s;
        rst = 1'b1;
        model_clear();
        s = nop();
        s.r1 = 5'($urandom_range(1, 31)); s.r2 = 5'($urandom_range(1, 31));
        s.rs1 = 5'($urandom_range(1, 31)); s.rd = 5'($urandom_range(1, 31));
        raddr1_i = s.r1; raddr2_i = s.r2;
        dec_rs1_i = s.rs1; dec_rs2_i = s.rs2; dec_rd_i = s.rd;
        we_i = 1'b0; issue_i = 1'b1; issue_rd_i = 5'd6; flush_i = 1'b0;
        e.rdata1 = 32'h0; e.rdata2 = 32'h0; e.stall = 1'b0; e.idle = 1'b1; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_i = 1'b0;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.tag, " rdata1"}, rdata1_o, e.rdata1);
            cmp({e.tag, " rdata2"}, rdata2_o, e.rdata2);
            cmp({e.tag, " stall"}, 32'(stall_o), 32'(e.stall));
            cmp({e.tag, " idle"}, 32'(idle_o), 32'(e.idle));
        end
    end

    task automatic random_traffic(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = nop();
            s.we    = ($urandom_range(0, 2) != 0);
            s.waddr = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
            s.wdata = $urandom;
            s.r1    = 5'($urandom_range(0, 12));
            s.r2    = 5'($urandom);
            s.rs1   = 5'($urandom_range(0, 11));
            s.rs2   = 5'($urandom_range(0, 11));
            s.rd    = 5'($urandom_range(0, 11));
            s.flush = ($urandom_range(0, 24) == 0);
            // Decode only issues when it would not stall.
            if (!model_stall(s) && $urandom_range(0, 2) == 0) begin
                s.issue = 1'b1;
                s.ird   = 5'($urandom_range(0, 11));
            end
            apply(s, "rand");
        end
    endtask

    initial begin
        stim_t s;
        model_clear();
        @(posedge clk);
        #1;
        do_reset("reset0");

        // x0 is never written nor reserved.
        s = nop(); s.we = 1'b1; s.waddr = 5'd0; s.wdata = 32'hDEADBEEF; s.issue = 1'b1; s.ird = 5'd0;
        apply(s, "x0_wr");
        s = nop(); s.r1 = 5'd0; s.r2 = 5'd0;
        apply(s, "x0_rd");

        // Write x5, read in the write cycle and the next one.
        s = nop(); s.we = 1'b1; s.waddr = 5'd5; s.wdata = 32'h1234_5678; s.r1 = 5'd5;
        apply(s, "wr_same");
        s = nop(); s.r1 = 5'd5; s.r2 = 5'd5;
        apply(s, "wr_next");

        // RAW on x7.
        s = nop(); s.issue = 1'b1; s.ird = 5'd7;
        apply(s, "raw_issue");
        for (int i = 0; i < 3; i++) begin
            s = nop(); s.rs2 = 5'd7;
            apply(s, "raw_wait");
        end
        s = nop(); s.rs2 = 5'd7; s.we = 1'b1; s.waddr = 5'd7; s.wdata = 32'hCAFE_0007; s.r2 = 5'd7;
        apply(s, "raw_wb");
        s = nop(); s.rs2 = 5'd7; s.r2 = 5'd7;
        apply(s, "raw_done");

        // Set/clear race on x9.
        s = nop(); s.issue = 1'b1; s.ird = 5'd9;
        apply(s, "race_issue");
        s = nop(); s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'h0000_0909;
        s.issue = 1'b1; s.ird = 5'd9; s.rs1 = 5'd9;
        apply(s, "race_edge");
        s = nop(); s.rs1 = 5'd9; s.r1 = 5'd9;
        apply(s, "race_after");

        // Flush drops every reservation, including a same-cycle issue, but not the write.
        s = nop(); s.we = 1'b1; s.waddr = 5'd9; s.wdata = 32'h0000_9999;
        apply(s, "fl_clr9");
        foreach (s.rd[i]) ;
        s = nop(); s.issue = 1'b1; s.ird = 5'd3;  apply(s, "fl_res3");
        s = nop(); s.issue = 1'b1; s.ird = 5'd4;  apply(s, "fl_res4");
        s = nop(); s.issue = 1'b1; s.ird = 5'd10; s.rs1 = 5'd3; s.rs2 = 5'd4;
        apply(s, "fl_res10");
        s = nop(); s.flush = 1'b1; s.issue = 1'b1; s.ird = 5'd11;
        s.we = 1'b1; s.waddr = 5'd12; s.wdata = 32'hF00D_000C; s.rs1 = 5'd10;
        apply(s, "fl_edge");
        s = nop(); s.rs1 = 5'd3; s.rs2 = 5'd11; s.rd = 5'd10; s.r1 = 5'd12;
        apply(s, "fl_after");

        random_traffic(400);

        // Asynchronous reset mid-run after traffic, then read back.
        do_reset("reset_mid");
        for (int i = 0; i < 8; i++) begin
            s = nop(); s.r1 = 5'($urandom_range(1, 12)); s.r2 = 5'($urandom);
            s.rs1 = 5'($urandom_range(1, 11)); s.rd = 5'($urandom_range(1, 11));
            apply(s, "post_reset");
        end

        random_traffic(200);

        apply(nop(), "drain");
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
